goal_event_ctrl: RTL
====================

Name: goal_event_ctrl

Overview:
- Match-flow controller for the foosball game.
- Receives goal-hit pulses from the collision logic and arbitrates simultaneous hits.
- Keeps both scores and sequences PLAY / FREEZE / SERVE / OVER.
- Drives the Level and freeze controls consumed by the goal-motion block and the ball serve logic.

Parameters:
FREEZE_FRAMES, 60, frames goals/ball stay frozen after a goal (1..255)
GOALS_PER_LEVEL, 3, total goals (both sides) per Level step
WIN_SCORE, 7, score that ends the match (1..15)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
startOfFrame  in  1  one-clk pulse per video frame
startGame  in  1  one-clk pulse, start/restart request
teamGoalHit  in  1  one-clk pulse, ball entered team goal (opponent scores)
oppGoalHit  in  1  one-clk pulse, ball entered opponent goal (team scores)
Level  out  2  difficulty level to goal-motion block, 0..3
freezeGoals  out  1  1 = hold goals and ball still
ballServe  out  1  one-clk pulse, re-centre and launch ball
scoreTeam  out  4  team score
scoreOpp  out  4  opponent score
gameOver  out  1  match finished
winnerTeam  out  1  valid when gameOver; 1 = team won
stateDbg  out  3  current state encoding: IDLE=0, SERVE=1, PLAY=2, FREEZE=3, OVER=4

Behaviour:
- Reset (async, high): state=IDLE, Level=0, scores=0, goalCnt=0, freezeCnt=0, lastScorerTeam=0.
- Reset outputs: freezeGoals=1, ballServe=0, gameOver=0, winnerTeam=0.
- All outputs are registered. Reset asserted mid-match aborts immediately to these values.
- IDLE:
  - freezeGoals=1.
  - startGame -> SERVE. On that edge, clear scores, goalCnt and Level.
- SERVE:
  - Lasts exactly one clk. ballServe=1 during this cycle only.
  - Next state PLAY. freezeGoals=1 in SERVE.
- PLAY:
  - freezeGoals=0.
  - Goal hit pulses are sampled every clk, not gated by startOfFrame.
  - Single hit: oppGoalHit increments scoreTeam; teamGoalHit increments scoreOpp.
  - Both hits in the same cycle (arbitration): exactly one goal is awarded, to the side that did NOT score last (lastScorerTeam=1 -> opponent wins the tie). The other hit is dropped.
  - On an awarded goal:
    - update lastScorerTeam; goalCnt+1.
    - If the new goalCnt is a multiple of GOALS_PER_LEVEL and Level<3: Level+1. Level saturates at 3.
    - If the new score == WIN_SCORE: -> OVER, winnerTeam = scorer.
    - Otherwise -> FREEZE, with freezeCnt=FREEZE_FRAMES.
  - startGame in PLAY is ignored.
- FREEZE:
  - freezeGoals=1. Goal hits are ignored.
  - Each startOfFrame decrements freezeCnt.
  - A startOfFrame seen with freezeCnt==1 -> SERVE. The freeze therefore spans exactly FREEZE_FRAMES frame pulses.
  - startGame is ignored.
- OVER:
  - gameOver=1, freezeGoals=1. Scores, Level and winnerTeam are held. Hits are ignored.
  - startGame -> SERVE with scores, goalCnt and Level cleared. gameOver drops on the same edge.
- Width rules:
  - goalCnt is 5 bits. It cannot overflow, because the match ends at 2*WIN_SCORE-1 <= 29 goals.
  - Scores never exceed WIN_SCORE.
- Latency: a hit pulse at edge N produces updated score, Level, state and freezeGoals visible after edge N+1 (one registered stage).
- A startOfFrame coincident with a goal in PLAY does not pre-decrement freezeCnt.

Test Plan:
- Reset then startGame -> one cycle later ballServe=1 for 1 clk, stateDbg=1. Next cycle stateDbg=2, freezeGoals=0, Level=0.
- In PLAY, one oppGoalHit -> scoreTeam=1, freezeGoals=1, stateDbg=3. After exactly 60 startOfFrame pulses, ballServe pulses, then PLAY resumes. Hits during FREEZE leave scores unchanged.
- Three goals (team, opp, team) -> Level goes 0,0,1. Nine goals -> Level=3. Further goals keep Level=3.
- teamGoalHit and oppGoalHit in the same cycle after the team scored last -> scoreOpp+1 only. Repeat right after the opponent scored -> scoreTeam+1 only.
- Team reaches 7 (opp 6, 13 goals) -> gameOver=1, winnerTeam=1, stateDbg=4, no ballServe. startGame -> scores 0/0, Level=0, ballServe pulse, gameOver=0.
- Assert reset during FREEZE with freezeCnt=30 -> outputs return to reset values asynchronously, before the next clk edge. After release, stateDbg=0 and hits are ignored until startGame.

Source files
------------

// File: rtl/goal_event_ctrl.sv
// Match-flow controller for the foosball game: arbitrates goal hits, keeps
// scores and Level, and sequences IDLE / SERVE / PLAY / FREEZE / OVER.
module goal_event_ctrl #(
    parameter int FREEZE_FRAMES   = 60,
    parameter int GOALS_PER_LEVEL = 3,
    parameter int WIN_SCORE       = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       startGame,
    input  logic       teamGoalHit,
    input  logic       oppGoalHit,
    output logic [1:0] Level,
    output logic       freezeGoals,
    output logic       ballServe,
    output logic [3:0] scoreTeam,
    output logic [3:0] scoreOpp,
    output logic       gameOver,
    output logic       winnerTeam,
    output logic [2:0] stateDbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SERVE  = 3'd1,
        PLAY   = 3'd2,
        FREEZE = 3'd3,
        OVER   = 3'd4
    } state_t;

    state_t     state;
    logic [4:0] goal_cnt;
    logic [7:0] freeze_cnt;
    logic       last_scorer_team;

    logic       award_team;
    logic       award_opp;
    logic [4:0] goal_next;
    logic [3:0] team_next;
    logic [3:0] opp_next;
    logic       level_step;
    logic       win;

    assign stateDbg = state;

    // A simultaneous hit goes to whichever side did not score last.
    always_comb begin
        award_team = 1'b0;
        award_opp  = 1'b0;
        if (oppGoalHit && teamGoalHit) begin
            award_team = ~last_scorer_team;
            award_opp  = last_scorer_team;
        end else begin
            award_team = oppGoalHit;
            award_opp  = teamGoalHit;
        end
        goal_next  = goal_cnt + 5'd1;
        team_next  = scoreTeam + 4'd1;
        opp_next   = scoreOpp + 4'd1;
        level_step = ((goal_next % 5'(GOALS_PER_LEVEL)) == 5'd0);
        win        = award_team ? (team_next == 4'(WIN_SCORE))
                                : (opp_next == 4'(WIN_SCORE));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            Level            <= '0;
            scoreTeam        <= '0;
            scoreOpp         <= '0;
            goal_cnt         <= '0;
            freeze_cnt       <= '0;
            last_scorer_team <= 1'b0;
            freezeGoals      <= 1'b1;
            ballServe        <= 1'b0;
            gameOver         <= 1'b0;
            winnerTeam       <= 1'b0;
        end else begin
            ballServe <= 1'b0;
            case (state)
                IDLE: begin
                    freezeGoals <= 1'b1;
                    if (startGame) begin
                        state     <= SERVE;
                        ballServe <= 1'b1;
                        scoreTeam <= '0;
                        scoreOpp  <= '0;
                        goal_cnt  <= '0;
                        Level     <= '0;
                    end
                end
                SERVE: begin
                    state       <= PLAY;
                    freezeGoals <= 1'b0;
                end
                PLAY: begin
                    if (award_team || award_opp) begin
                        last_scorer_team <= award_team;
                        goal_cnt         <= goal_next;
                        freezeGoals      <= 1'b1;
                        if (award_team) begin
                            scoreTeam <= team_next;
                        end else begin
                            scoreOpp <= opp_next;
                        end
                        if (level_step && (Level != 2'd3)) begin
                            Level <= Level + 2'd1;
                        end
                        if (win) begin
                            state      <= OVER;
                            gameOver   <= 1'b1;
                            winnerTeam <= award_team;
                        end else begin
                            state      <= FREEZE;
                            freeze_cnt <= 8'(FREEZE_FRAMES);
                        end
                    end
                end
                FREEZE: begin
                    freezeGoals <= 1'b1;
                    if (startOfFrame) begin
                        if (freeze_cnt == 8'd1) begin
                            state      <= SERVE;
                            ballServe  <= 1'b1;
                            freeze_cnt <= '0;
                        end else begin
                            freeze_cnt <= freeze_cnt - 8'd1;
                        end
                    end
                end
                OVER: begin
                    freezeGoals <= 1'b1;
                    if (startGame) begin
                        state     <= SERVE;
                        ballServe <= 1'b1;
                        gameOver  <= 1'b0;
                        scoreTeam <= '0;
                        scoreOpp  <= '0;
                        goal_cnt  <= '0;
                        Level     <= '0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    freezeGoals <= 1'b1;
                end
            endcase
        end
    end

endmodule
